// File: rtl/uart_tx_unit.sv
// uart_tx_unit
//   Serial UART transmitter driven by a 16x-oversampling baud tick.
//   Sends a frame made of one start bit, DBIT data bits (LSB first), an
//   optional parity bit and a stop period of SB_TICK ticks.
//
// Ports
//   clk           system clock
//   reset         synchronous, active-low reset
//   tx_start      request to send din, sampled only while idle
//   s_tick        one-clk-wide 16x baud tick
//   din           byte to send, bits [DBIT-1:0] are used
//   tx            registered serial line, idles high
//   tx_busy       high whenever a frame is in progress
//   tx_done_tick  one-clk pulse on the last tick of the stop period
//
// Parameters
//   DBIT     data bits per frame (5..8)
//   SB_TICK  ticks in the stop period (16, 24 or 32)
//   PARITY   0 = none, 1 = even, 2 = odd
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | line high, waiting for tx_start
// START | driving the start bit (low) for 16 ticks
// DATA  | shifting data bits out LSB first, 16 ticks each
// PAR   | driving the parity bit for 16 ticks (PARITY != 0 only)
// STOP  | line high for SB_TICK ticks, then done pulse

module uart_tx_unit #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int PARITY  = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic       s_tick,
  input  logic [7:0] din,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done_tick
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] PAR   = 3'd3;
  localparam logic [2:0] STOP  = 3'd4;

  localparam logic [4:0] BIT_LAST  = 5'd15;
  localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] N_LAST    = 3'(DBIT - 1);

  logic [2:0] state;
  logic [4:0] s;
  logic [2:0] n;
  logic [7:0] b;
  logic       tx_reg;
  logic       par_acc;

  logic       par_next;
  logic       par_bit;

  // Running XOR including the bit currently on the line, so the parity bit
  // is ready the moment the last data bit finishes.
  assign par_next = par_acc ^ b[0];
  assign par_bit  = (PARITY == 2) ? ~par_next : par_next;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      s       <= 5'd0;
      n       <= 3'd0;
      b       <= 8'd0;
      tx_reg  <= 1'b1;
      par_acc <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx_reg <= 1'b1;
          if (tx_start) begin
            b       <= din;
            s       <= 5'd0;
            tx_reg  <= 1'b0;
            par_acc <= 1'b0;
            state   <= START;
          end
        end

        START: begin
          if (s_tick) begin
            if (s == BIT_LAST) begin
              s      <= 5'd0;
              n      <= 3'd0;
              tx_reg <= b[0];
              state  <= DATA;
            end else begin
              s <= s + 5'd1;
            end
          end
        end

        DATA: begin
          if (s_tick) begin
            if (s == BIT_LAST) begin
              s       <= 5'd0;
              b       <= {1'b0, b[7:1]};
              par_acc <= par_next;
              if (n == N_LAST) begin
                if (PARITY != 0) begin
                  tx_reg <= par_bit;
                  state  <= PAR;
                end else begin
                  tx_reg <= 1'b1;
                  state  <= STOP;
                end
              end else begin
                n      <= n + 3'd1;
                tx_reg <= b[1];
              end
            end else begin
              s <= s + 5'd1;
            end
          end
        end

        PAR: begin
          if (s_tick) begin
            if (s == BIT_LAST) begin
              s      <= 5'd0;
              tx_reg <= 1'b1;
              state  <= STOP;
            end else begin
              s <= s + 5'd1;
            end
          end
        end

        STOP: begin
          if (s_tick) begin
            if (s == STOP_LAST) begin
              s     <= 5'd0;
              state <= IDLE;
            end else begin
              s <= s + 5'd1;
            end
          end
        end

        default: begin
          tx_reg <= 1'b1;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign tx      = tx_reg;
  assign tx_busy = (state != IDLE);

  // Mealy pulse on the final stop tick; masked during reset so an aborted
  // frame never reports completion.
  assign tx_done_tick = reset && (state == STOP) && s_tick && (s == STOP_LAST);

endmodule

// File: tb/tb_uart_tx_unit.sv
module tb_uart_tx_unit;

  typedef struct {
    logic [7:0] data;
    logic       par;
    bit         b2b;
    bit         abort;
    int         clk_len;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_start0;
  logic       tx_startp;
  logic       s_tick;
  logic [7:0] din;

  logic tx_w   [3];
  logic busy_w [3];
  logic done_w [3];

  exp_t q [3][$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int tick_m = 1;
  int last_done [3] = '{-100, -100, -100};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // u_dut0: no parity (main DUT), u_dut1: even parity, u_dut2: odd parity
  uart_tx_unit #(.DBIT(8), .SB_TICK(16), .PARITY(0)) u_dut0 (
    .clk(clk), .reset(reset), .tx_start(tx_start0), .s_tick(s_tick), .din(din),
    .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done_tick(done_w[0]));
  uart_tx_unit #(.DBIT(8), .SB_TICK(16), .PARITY(1)) u_dut1 (
    .clk(clk), .reset(reset), .tx_start(tx_startp), .s_tick(s_tick), .din(din),
    .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done_tick(done_w[1]));
  uart_tx_unit #(.DBIT(8), .SB_TICK(16), .PARITY(2)) u_dut2 (
    .clk(clk), .reset(reset), .tx_start(tx_startp), .s_tick(s_tick), .din(din),
    .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done_tick(done_w[2]));

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Tick generator: s_tick is high for one clk out of every tick_m.
  initial begin
    int ph;
    ph = 0;
    s_tick = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ph = (ph + 1) % tick_m;
      s_tick = (ph == 0);
    end
  end

  // Monitor: decodes the line by counting baud ticks and sampling mid-bit.
  task automatic monitor(input int k);
    exp_t       e;
    int         cnt, ft, t0, done_cyc, guard, idx, np;
    bit         aborted, done_bad, exp_done;
    logic [10:0] fr;
    np = (k != 0) ? 1 : 0;
    ft = 16 * (1 + 8 + np) + 16;
    forever begin
      @(negedge clk);
      if (tx_w[k] === 1'b0) begin
        t0 = cyc; cnt = 0; aborted = 0; done_bad = 0;
        fr = '1; done_cyc = -1; guard = 0;
        while (cnt < ft) begin
          if (busy_w[k] !== 1'b1) begin
            aborted = 1;
            break;
          end
          exp_done = (s_tick === 1'b1) && (cnt == ft - 1);
          if (s_tick === 1'b1 && (cnt % 16) == 8) begin
            idx = cnt / 16;
            fr[idx] = tx_w[k];
          end
          if (done_w[k] !== exp_done) done_bad = 1;
          if (done_w[k] === 1'b1) done_cyc = cyc;
          if (s_tick === 1'b1) cnt++;
          if (cnt < ft) begin
            @(negedge clk);
            guard++;
            if (guard > 20000) begin
              total++; bad++;
              $display("FAIL dut%0d_frame_timeout: got %0d ticks expected %0d", k, cnt, ft);
              break;
            end
          end
        end
        if (q[k].size() == 0) begin
          total++; bad++;
          $display("FAIL dut%0d_unexpected_frame: got frame at cycle %0d expected none", k, t0);
        end else begin
          e = q[k].pop_front();
          chk($sformatf("dut%0d_abort", k), int'(aborted), int'(e.abort));
          chk($sformatf("dut%0d_done_pulse", k), int'(done_bad), 0);
          if (!aborted && !e.abort) begin
            chk($sformatf("dut%0d_start_bit", k), int'(fr[0]), 0);
            chk($sformatf("dut%0d_data", k), int'(fr[8:1]), int'(e.data));
            if (np != 0) chk($sformatf("dut%0d_parity", k), int'(fr[9]), int'(e.par));
            chk($sformatf("dut%0d_stop_bit", k), int'(fr[9 + np]), 1);
            chk($sformatf("dut%0d_frame_clks", k), done_cyc - t0 + 1, e.clk_len);
            if (e.b2b) chk($sformatf("dut%0d_gap", k), t0 - last_done[k], 2);
          end
          last_done[k] = done_cyc;
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);
  initial monitor(2);

  task automatic send(input logic [7:0] d, input bit to_main, input bit to_par);
    int g;
    g = 0;
    @(posedge clk); #2;
    while (s_tick !== 1'b1 && g < 100) begin
      @(posedge clk); #2;
      g++;
    end
    din = d;
    tx_start0 = to_main;
    tx_startp = to_par;
    @(posedge clk); #2;
    tx_start0 = 1'b0;
    tx_startp = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int g;
    g = 0;
    do begin
      @(posedge clk); #2;
      g++;
    end while (busy_w[k] !== 1'b0 && g < 5000);
    chk($sformatf("dut%0d_idle", k), int'(busy_w[k] === 1'b0), 1);
    repeat (3) @(posedge clk);
    #2;
  endtask

  initial begin
    int g;
    reset = 1'b0; tx_start0 = 1'b1; tx_startp = 1'b1; din = 8'hFF;

    // reset held with tx_start high
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_tx", int'(tx_w[0]), 1);
      chk("rst_busy", int'(busy_w[0]), 0);
      chk("rst_done", int'(done_w[0]), 0);
    end
    @(posedge clk); #2;
    reset = 1'b1; tx_start0 = 1'b0; tx_startp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_busy", int'(busy_w[0]), 0);
      chk("idle_tx", int'(tx_w[0]), 1);
    end

    // 0x55, s_tick tied high: 160 clk frame
    tick_m = 1;
    q[0].push_back('{8'h55, 1'b0, 1'b0, 1'b0, 160});
    send(8'h55, 1'b1, 1'b0);
    wait_idle(0);

    // 0xA3, s_tick every 4th clk: 640 clk frame
    tick_m = 4;
    q[0].push_back('{8'hA3, 1'b0, 1'b0, 1'b0, 640});
    send(8'hA3, 1'b1, 1'b0);
    wait_idle(0);

    // parity: 0x07 has three ones, 0x5A has four
    tick_m = 1;
    q[1].push_back('{8'h07, 1'b1, 1'b0, 1'b0, 176});
    q[2].push_back('{8'h07, 1'b0, 1'b0, 1'b0, 176});
    send(8'h07, 1'b0, 1'b1);
    wait_idle(1);
    wait_idle(2);
    q[1].push_back('{8'h5A, 1'b0, 1'b0, 1'b0, 176});
    q[2].push_back('{8'h5A, 1'b1, 1'b0, 1'b0, 176});
    send(8'h5A, 1'b0, 1'b1);
    wait_idle(1);
    wait_idle(2);

    // tx_start held high, din changes mid-frame
    q[0].push_back('{8'h11, 1'b0, 1'b0, 1'b0, 160});
    q[0].push_back('{8'h22, 1'b0, 1'b1, 1'b0, 160});
    @(posedge clk); #2;
    din = 8'h11; tx_start0 = 1'b1;
    repeat (50) begin @(posedge clk); #2; end
    din = 8'h22;
    g = 0;
    while (done_w[0] !== 1'b1 && g < 1000) begin @(posedge clk); #2; g++; end
    g = 0;
    while (busy_w[0] !== 1'b0 && g < 1000) begin @(posedge clk); #2; g++; end
    g = 0;
    while (busy_w[0] !== 1'b1 && g < 1000) begin @(posedge clk); #2; g++; end
    tx_start0 = 1'b0; din = 8'h00;
    wait_idle(0);

    // reset during data bit 3, then a clean frame
    q[0].push_back('{8'h3C, 1'b0, 1'b0, 1'b1, 0});
    send(8'h3C, 1'b1, 1'b0);
    repeat (69) begin @(posedge clk); #2; end
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_tx", int'(tx_w[0]), 1);
    chk("abort_busy", int'(busy_w[0]), 0);
    chk("abort_done", int'(done_w[0]), 0);
    reset = 1'b1;
    q[0].push_back('{8'h96, 1'b0, 1'b0, 1'b0, 160});
    send(8'h96, 1'b1, 1'b0);
    wait_idle(0);

    repeat (5) @(posedge clk);
    for (int k = 0; k < 3; k++) chk($sformatf("dut%0d_queue_empty", k), q[k].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
